// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of a single uart_tx.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    // Increment modulo n; n need not be a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module uart_rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    int            idx;
    logic [IW-1:0] sel;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        sel        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IW'(idx);
            if (!any && req[sel]) begin
                any             = 1'b1;
                gnt_idx         = sel;
                gnt_onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte producers,
// with a frame watchdog that recovers from a stuck tx_done.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DBIT   = 8,
    parameter int TO_CYC = 4096,
    parameter int IW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err,
    output logic [1:0]           state_dbg
);

    localparam int WW = $clog2(TO_CYC);

    // Handshake: a byte moves when req_valid[i] && req_ready[i] at a rising edge;
    // req_ready is one-hot, combinational, and only offered in ARB_IDLE with tx_done high.

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [WW-1:0]   wd_cnt_q;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            frame_end;
    logic            wd_hit;

    uart_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    assign wd_hit    = (wd_cnt_q == WW'(TO_CYC - 1));
    assign busy      = (state_q != ARB_IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        accept      = 1'b0;
        frame_end   = 1'b0;
        timeout_err = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (tx_done && pick_any) begin
                        req_ready = pick_onehot;
                        accept    = 1'b1;
                        state_d   = ARB_LAUNCH;
                    end
                end
                ARB_LAUNCH: state_d = ARB_WAIT_BUSY;
                // Exit condition is tested before the watchdog so a late edge still wins.
                ARB_WAIT_BUSY: begin
                    if (!tx_done) begin
                        state_d = ARB_WAIT_DONE;
                    end else if (wd_hit) begin
                        state_d     = ARB_IDLE;
                        frame_end   = 1'b1;
                        timeout_err = 1'b1;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (tx_done) begin
                        state_d   = ARB_IDLE;
                        frame_end = 1'b1;
                    end else if (wd_hit) begin
                        state_d     = ARB_IDLE;
                        frame_end   = 1'b1;
                        timeout_err = 1'b1;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            tx_din   <= '0;
            grant_id <= '0;
            tx_start <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_start <= accept;
            if (accept) begin
                tx_din   <= req_data[pick_idx*DBIT +: DBIT];
                grant_id <= pick_idx;
            end
            if (state_q == ARB_LAUNCH) begin
                wd_cnt_q <= '0;
            end else if (state_q == ARB_WAIT_BUSY || state_q == ARB_WAIT_DONE) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (frame_end) begin
                rr_ptr_q <= IW'(wrap_inc(int'(grant_id), NREQ));
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: arbiter paired with a behavioural uart_tx (16 clk per bit), plus a
// second arbiter with a short watchdog whose tx_done is driven directly.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, uart_rst;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic        tx_start, tx_done, busy, timeout_err;
    logic [7:0]  tx_din;
    logic [1:0]  grant_id, state_dbg;

    logic [3:0]  w_valid, w_ready;
    logic [31:0] w_data;
    logic        w_start, w_done, w_busy, w_to;
    logic [7:0]  w_din;
    logic [1:0]  w_gid, w_state;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TO_CYC(4096)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TO_CYC(8)) dut_wd (
        .clk(clk), .rst(rst), .req_valid(w_valid), .req_data(w_data),
        .req_ready(w_ready), .tx_start(w_start), .tx_din(w_din), .tx_done(w_done),
        .busy(w_busy), .grant_id(w_gid), .timeout_err(w_to), .state_dbg(w_state)
    );

    // uart_tx stand-in: start bit, 8 data bits LSB first, stop bit; 16 clk per bit.
    logic [9:0] u_shift;
    logic       u_busy;
    logic [3:0] u_tick, u_bit;
    logic       tx_line;
    assign tx_line = u_busy ? u_shift[0] : 1'b1;

    always @(posedge clk) begin
        if (uart_rst) begin
            u_busy  <= 1'b0;
            tx_done <= 1'b1;
            u_tick  <= '0;
            u_bit   <= '0;
            u_shift <= '1;
        end else if (!u_busy) begin
            if (tx_start) begin
                u_shift <= {1'b1, tx_din, 1'b0};
                u_busy  <= 1'b1;
                tx_done <= 1'b0;
                u_tick  <= '0;
                u_bit   <= '0;
            end
        end else begin
            u_tick <= u_tick + 1'b1;
            if (u_tick == 4'd15) begin
                u_shift <= {1'b1, u_shift[9:1]};
                u_bit   <= u_bit + 1'b1;
                if (u_bit == 4'd9) begin
                    u_busy  <= 1'b0;
                    tx_done <= 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in ARB_IDLE with inputs already applied; returns at the
    // negedge where busy has just dropped.
    task automatic serve(input logic [3:0] exp_rdy, input logic [1:0] exp_gid,
                         input logic [7:0] exp_byte, input logic [9:0] exp_bits,
                         input logic [3:0] drop);
        logic [9:0] bits;
        bits = '0;
        #1 chk("req_ready", req_ready, exp_rdy);
        @(negedge clk);
        req_valid = req_valid & ~drop;
        chk("tx_start", tx_start, 1);
        chk("grant_id", grant_id, exp_gid);
        chk("tx_din", tx_din, exp_byte);
        chk("busy_launch", busy, 1);
        @(negedge clk);
        chk("tx_start_1cyc", tx_start, 0);
        chk("ready_in_frame", req_ready, 0);
        tick(7);
        for (int k = 0; k < 10; k++) begin
            bits[k] = tx_line;
            if (k < 9) tick(16);
        end
        chk("serial", bits, exp_bits);
        tick(9);
        chk("busy_tail", busy, 1);
        chk("done_tail", tx_done, 1);
        tick(1);
        chk("busy_drop", busy, 0);
    endtask

    initial begin
        int n;
        n         = 0;
        rst       = 1'b1;
        uart_rst  = 1'b1;
        req_valid = 4'hF;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        w_valid   = 4'hF;
        w_data    = {8'h00, 8'h88, 8'h77, 8'h00};
        w_done    = 1'b1;

        // Reset with every requester valid.
        tick(2);
        chk("rst_ready", req_ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_w_busy", w_busy, 0);
        uart_rst  = 1'b0;
        rst       = 1'b0;
        req_valid = 4'h0;
        w_valid   = 4'h0;
        tick(1);

        // Watchdog: tx_done never falls, abort on the 8th waiting cycle.
        w_valid = 4'b0010;
        #1 chk("wd_ready", w_ready, 4'b0010);
        @(negedge clk);
        chk("wd_start", w_start, 1);
        chk("wd_gid", w_gid, 1);
        chk("wd_din", w_din, 8'h77);
        w_valid = 4'b0110;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("wd_timeout", w_to, (k == 8));
            chk("wd_busy", w_busy, 1);
        end
        tick(1);
        chk("wd_to_clear", w_to, 0);
        chk("wd_idle", w_busy, 0);
        #1 chk("wd_next_grant", w_ready, 4'b0100);
        @(negedge clk);
        chk("wd_start2", w_start, 1);
        chk("wd_gid2", w_gid, 2);
        w_valid = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("wd_quiet", w_to, 0);
        end
        tick(1);
        w_done = 1'b0;
        #1 chk("wd_exit_prio", w_to, 0);
        @(negedge clk);
        chk("wd_state_done", w_state, 3);
        w_done = 1'b1;
        #1 chk("wd_exit_prio2", w_to, 0);
        @(negedge clk);
        chk("wd_state_idle", w_state, 0);
        chk("wd_busy_end", w_busy, 0);
        w_valid = 4'b1000;
        w_done  = 1'b0;
        #1 chk("wd_done_low_nogrant", w_ready, 0);
        w_valid = 4'h0;
        w_done  = 1'b1;

        // Single requester 2, byte A5.
        @(negedge clk);
        req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        req_valid = 4'b0100;
        serve(4'b0100, 2'd2, 8'hA5, 10'b1101001010, 4'b0100);

        // All valid after a fresh reset: grants 0,1,2,3,0.
        rst = 1'b1;
        tick(1);
        rst       = 1'b0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        serve(4'b0001, 2'd0, 8'h10, {1'b1, 8'h10, 1'b0}, 4'h0);
        serve(4'b0010, 2'd1, 8'h11, {1'b1, 8'h11, 1'b0}, 4'h0);
        serve(4'b0100, 2'd2, 8'h12, {1'b1, 8'h12, 1'b0}, 4'h0);
        serve(4'b1000, 2'd3, 8'h13, {1'b1, 8'h13, 1'b0}, 4'h0);
        serve(4'b0001, 2'd0, 8'h10, {1'b1, 8'h10, 1'b0}, 4'h0);
        req_valid = 4'h0;

        // req0 always valid must not lock out req3 (pointer now at 1).
        req_data  = {8'hC3, 8'h00, 8'h00, 8'h3C};
        req_valid = 4'b1001;
        serve(4'b1000, 2'd3, 8'hC3, {1'b1, 8'hC3, 1'b0}, 4'h0);
        serve(4'b0001, 2'd0, 8'h3C, {1'b1, 8'h3C, 1'b0}, 4'h0);
        serve(4'b1000, 2'd3, 8'hC3, {1'b1, 8'hC3, 1'b0}, 4'hF);

        // Reset in ARB_WAIT_DONE; pointer returns to 0 so req0 beats req2.
        req_data  = {8'h00, 8'h66, 8'h99, 8'h5A};
        req_valid = 4'b0110;
        #1 chk("mid_ready", req_ready, 4'b0010);
        @(negedge clk);
        chk("mid_start", tx_start, 1);
        chk("mid_gid", grant_id, 1);
        req_valid = 4'b0101;
        tick(2);
        chk("mid_state", state_dbg, 3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_din", tx_din, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gid", grant_id, 0);
        chk("mid_rst_to", timeout_err, 0);
        chk("mid_rst_state", state_dbg, 0);
        rst = 1'b0;
        #1 chk("mid_done_low_nogrant", req_ready, 0);
        while (tx_done !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        chk("mid_done_wait", tx_done, 1);
        serve(4'b0001, 2'd0, 8'h5A, {1'b1, 8'h5A, 1'b0}, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not finish");
    end

endmodule
